// File: rtl/z16_pkg.sv
// Shared widths, encodings and types for the Z16 instruction-fetch front end.
package z16_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    // STOP is encoded as a self-loop jump: JRL 0 ZR G11
    localparam logic [INSTR_W-1:0] HALT_INSTR_DEFAULT = 16'h00FD;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/z16_fetch_fifo.sv
// Small circular buffer of {pc, instr} entries between fetch and decode.
// Flush discards everything in one cycle; a full FIFO may push and pop together.
module z16_fetch_fifo
    import z16_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  fetch_entry_t            wr_entry,
    output fetch_entry_t            head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Pointers wrap for free because DEPTH is a power of two
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 instruction-fetch front end: drives the imem address, buffers {pc, instr}
// pairs for decode, handles redirects and freezes after the STOP instruction.
//
//   state  | meaning
//   FETCH  | one instruction pushed per cycle whenever the FIFO can take it
//   HALTED | STOP has been pushed; fetch frozen until redirect or reset
module z16_fetch_unit
    import z16_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC   = 16'h0000,
    parameter int                 DEPTH      = 2,
    parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic [ADDR_W-1:0]   o_imem_addr,
    input  logic [INSTR_W-1:0]  i_imem_instr,
    output logic                o_valid,
    output logic [INSTR_W-1:0]  o_instr,
    output logic [ADDR_W-1:0]   o_pc,
    input  logic                i_ready,
    input  logic                i_redirect,
    input  logic [ADDR_W-1:0]   i_redirect_pc,
    output logic                o_halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("z16_fetch_unit: DEPTH must be a power of two and at least 2");
        end
        if (RESET_PC[0] != 1'b0) begin : g_bad_reset_pc
            $error("z16_fetch_unit: RESET_PC must be halfword aligned");
        end
    endgenerate

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    fetch_entry_t       wr_entry;
    fetch_entry_t       head;

    assign pop  = o_valid & i_ready;
    assign push = (state == FETCH) & ~i_redirect & ((count < CNT_W'(DEPTH)) | pop);

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = i_imem_instr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_redirect) begin
            state_nxt = FETCH;
        end else if (push && (i_imem_instr == HALT_INSTR)) begin
            state_nxt = HALTED;
        end
    end

    always_comb begin
        o_halted = (state == HALTED);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc <= RESET_PC;
        end else if (i_redirect) begin
            fetch_pc <= align_pc(i_redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + 16'd2;
        end
    end

    z16_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .flush    (i_redirect),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign o_imem_addr = fetch_pc;
    assign o_valid     = (count != '0);
    assign o_instr     = head.instr;
    assign o_pc        = head.pc;

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Bench for z16_fetch_unit: queue-based fetch model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_z16_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          DEPTH    = 2;
    localparam logic [15:0] HALT     = 16'h00FD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    always #5 clk = ~clk;

    logic [15:0] mem [0:32767];
    assign imem_instr = mem[imem_addr[15:1]];

    z16_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .DEPTH      (DEPTH),
        .HALT_INSTR (HALT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_addr   (imem_addr),
        .i_imem_instr  (imem_instr),
        .o_valid       (valid),
        .o_instr       (instr),
        .o_pc          (pc),
        .i_ready       (ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_halted      (halted)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model state: queue of {pc, instr} waiting for decode, next fetch address, halt flag
    logic [31:0] q [$];
    logic [15:0] m_pc;
    bit          m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_step();
        bit          pop_now;
        bit          push_now;
        logic [15:0] word;
        if (rst) begin
            q.delete();
            m_pc   = RESET_PC;
            m_halt = 1'b0;
            return;
        end
        pop_now  = (q.size() != 0) && ready;
        push_now = !m_halt && !redirect && ((q.size() < DEPTH) || pop_now);
        if (redirect) begin
            q.delete();
            m_pc   = {redirect_pc[15:1], 1'b0};
            m_halt = 1'b0;
            return;
        end
        if (pop_now) void'(q.pop_front());
        if (push_now) begin
            word = mem[m_pc[15:1]];
            q.push_back({m_pc, word});
            m_pc = m_pc + 16'd2;
            if (word == HALT) m_halt = 1'b1;
        end
    endtask

    task automatic compare();
        chk("valid", {31'd0, valid}, {31'd0, q.size() != 0});
        chk("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        if (q.size() != 0) begin
            chk("head_pc", {16'd0, pc}, {16'd0, q[0][31:16]});
            chk("head_instr", {16'd0, instr}, {16'd0, q[0][15:0]});
        end
    endtask

    // Inputs change at the falling edge; model advances at the rising edge; outputs checked at the next falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i] == HALT) mem[i] = HALT ^ 16'h0100;
        end
        mem[0]  = 16'h0010;
        mem[1]  = 16'h0119;
        mem[14] = HALT;                         // byte address 16'h001C

        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        tick();
        tick();
        chk("rst_addr",   {16'd0, imem_addr}, {16'd0, RESET_PC});
        chk("rst_valid",  {31'd0, valid},  32'd0);
        chk("rst_instr",  {16'd0, instr},  32'd0);
        chk("rst_pc",     {16'd0, pc},     32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // Streaming
        rst = 1'b0; ready = 1'b1;
        chk("stream_valid_c1", {31'd0, valid}, 32'd0);
        tick();
        chk("stream_valid_c2", {31'd0, valid}, 32'd1);
        chk("stream_pc0",    {16'd0, pc},    32'h0000);
        chk("stream_instr0", {16'd0, instr}, 32'h0010);
        tick();
        chk("stream_pc1",    {16'd0, pc},    32'h0002);
        chk("stream_instr1", {16'd0, instr}, 32'h0119);
        tick();
        chk("stream_pc2",    {16'd0, pc},    32'h0004);

        // Backpressure
        rst = 1'b1;
        tick();
        rst = 1'b0; ready = 1'b0;
        repeat (6) tick();
        chk("bp_addr",        {16'd0, imem_addr}, 32'h0004);
        chk("bp_model_count", q.size(), 32'd2);
        chk("bp_head0",       {16'd0, pc}, 32'h0000);
        ready = 1'b1;
        tick();
        chk("bp_head1", {16'd0, pc}, 32'h0002);
        tick();
        chk("bp_head2", {16'd0, pc}, 32'h0004);
        tick();

        // Redirect mid-stream to an odd address
        redirect = 1'b1; redirect_pc = 16'h0013;
        tick();
        redirect = 1'b0;
        chk("redir_valid", {31'd0, valid}, 32'd0);
        chk("redir_addr",  {16'd0, imem_addr}, 32'h0012);
        tick();
        chk("redir_head_valid", {31'd0, valid}, 32'd1);
        chk("redir_head_pc",    {16'd0, pc}, 32'h0012);

        // Halt on STOP at 16'h001C
        redirect = 1'b1; redirect_pc = 16'h0014;
        tick();
        redirect = 1'b0;
        repeat (5) tick();
        chk("halt_pc",     {16'd0, pc},        32'h001C);
        chk("halt_instr",  {16'd0, instr},     32'h00FD);
        chk("halt_flag",   {31'd0, halted},    32'd1);
        chk("halt_addr",   {16'd0, imem_addr}, 32'h001E);
        repeat (10) begin
            tick();
            chk("halt_frozen_addr", {16'd0, imem_addr}, 32'h001E);
        end
        chk("halt_drained", {31'd0, valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        chk("unhalt_flag", {31'd0, halted},    32'd0);
        chk("unhalt_addr", {16'd0, imem_addr}, 32'h0000);
        tick();
        chk("unhalt_pc",   {16'd0, pc},        32'h0000);
        chk("unhalt_next", {16'd0, imem_addr}, 32'h0002);

        // Wrap-around
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap_pc0", {16'd0, pc}, 32'hFFFE);
        tick();
        chk("wrap_pc1", {16'd0, pc}, 32'h0000);
        tick();
        chk("wrap_pc2", {16'd0, pc}, 32'h0002);

        // Reset beats redirect with a full FIFO
        ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
        tick();
        chk("rstredir_valid",  {31'd0, valid},     32'd0);
        chk("rstredir_halted", {31'd0, halted},    32'd0);
        chk("rstredir_addr",   {16'd0, imem_addr}, {16'd0, RESET_PC});
        rst = 1'b0; redirect = 1'b0;

        // Randomized traffic with STOP words scattered through memory
        for (int i = 0; i < 32768; i++) begin
            if ($urandom_range(0, 31) == 0) mem[i] = HALT;
        end
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            ready    = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 16'($urandom_range(65528, 65535));
            else                           redirect_pc = 16'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/z16_fetch_unit.md
# z16_fetch_unit

Instruction-fetch front end for the Z16 CPU. It is the initiator of the instruction-memory read interface: it drives the fetch address, samples the returned 16-bit instruction and buffers {pc, instr} pairs in a small FIFO. Decode pulls from that FIFO through a valid/ready handshake. The block also handles branch/jump redirects and stops fetching after the Z16 self-loop STOP instruction.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address after reset; bit 0 must be 0.
- DEPTH, 2, number of FIFO entries; must be a power of two, at least 2.
- HALT_INSTR, 16'h00FD, STOP encoding (JRL 0 ZR G11).

Ports:
- i_clk  in  1  clock; everything is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_imem_addr  out  16  instruction-memory byte address; always even.
- i_imem_instr  in  16  instruction returned combinationally for o_imem_addr.
- o_valid  out  1  the FIFO head is valid.
- o_instr  out  16  FIFO head instruction.
- o_pc  out  16  FIFO head byte address.
- i_ready  in  1  decode accepts the head this cycle.
- i_redirect  in  1  flush the FIFO and restart fetch.
- i_redirect_pc  in  16  restart address; bit 0 is ignored (forced to 0).
- o_halted  out  1  fetch has stopped after pushing HALT_INSTR.

## Operation
- Internal registers:
  - fetch_pc, 16 bits.
  - FIFO with read pointer, write pointer and a count of width log2(DEPTH)+1.
  - state: FETCH or HALTED.
- Address: o_imem_addr = fetch_pc, combinationally. Instruction memory is asynchronous-read, so i_imem_instr is valid in the same cycle.
- pop = o_valid & i_ready.
- push = (state==FETCH) & ~i_redirect & (count<DEPTH | pop).
- On push:
  - write {fetch_pc, i_imem_instr} at the write pointer;
  - fetch_pc <= fetch_pc + 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
- Without push, fetch_pc holds.
- Full and popping in the same cycle: push is allowed and count is unchanged.
- Empty and pushing: the entry becomes visible the next cycle. There is no bypass from i_imem_instr to o_instr.
- Head outputs: o_instr and o_pc come from the entry at the read pointer; o_valid = (count != 0).
- HALT detection: a push whose i_imem_instr == HALT_INSTR moves the state FETCH -> HALTED.
  - The STOP instruction itself is still pushed and delivered.
  - fetch_pc holds at the STOP address + 2.
  - No further pushes while in HALTED.
  - o_halted = (state==HALTED).
- Redirect: when i_redirect=1 in a cycle,
  - a pop in that same cycle still counts as a completed transfer;
  - all entries are discarded and count <= 0;
  - fetch_pc <= {i_redirect_pc[15:1], 1'b0};
  - state <= FETCH, which also clears HALTED;
  - no push occurs in that cycle.
- Reset (i_rst=1, including mid-operation):
  - fetch_pc <= RESET_PC;
  - count, read pointer and write pointer <= 0;
  - state <= FETCH;
  - FIFO data <= 0.
- Reset has priority over redirect; redirect has priority over push.

## Timing
- Reset values of outputs:
  - o_imem_addr = RESET_PC;
  - o_valid = 0, o_instr = 16'h0000, o_pc = 16'h0000;
  - o_halted = 0.
- First push happens in the first cycle after i_rst drops. o_valid rises one cycle later.
- Throughput: one instruction per cycle while i_ready=1 and no redirect.
- Fetch-to-decode latency: 1 cycle.
- Redirect penalty: o_valid=0 in the cycle after i_redirect. The redirect target appears at the head 2 cycles after i_redirect.
- With i_ready held at 0, the FIFO fills after DEPTH pushes and o_imem_addr freezes at RESET_PC + 2*DEPTH (from reset).
- o_valid/o_instr/o_pc are registered (FIFO outputs) and have no combinational dependence on i_ready or i_redirect.

## Structure
- Package z16_pkg holds:
  - INSTR_W=16 and ADDR_W=16;
  - the HALT_INSTR default 16'h00FD;
  - fetch_state_t {FETCH, HALTED}.
- Sub-module z16_fetch_fifo (32-bit wide, DEPTH entries) provides synchronous flush, push, pop and count.
- The top level keeps fetch_pc, the state machine and the push/redirect logic.

## Test plan
- Streaming: reset, then i_ready=1 with memory returning 16'h0010 @0 and 16'h0119 @2.
  - Required: o_valid rises in cycle 2; o_pc = 0,2,4,... on consecutive cycles; o_instr matches memory.
- Backpressure: i_ready=0 for 6 cycles after reset.
  - Required: o_imem_addr stops at 16'h0004 with count=2.
  - Required: after releasing i_ready, heads arrive in order at pc 0,2,4 with no loss or duplication.
- Redirect mid-stream: i_redirect=1 with i_redirect_pc=16'h0013.
  - Required: next cycle o_valid=0 and o_imem_addr=16'h0012.
  - Required: the following cycle o_pc=16'h0012.
- Halt: memory returns 16'h00FD at 16'h001C.
  - Required: that entry is delivered; o_halted=1; o_imem_addr stays at 16'h001E; no further pushes for 10 cycles.
  - Required: a redirect to 16'h0000 clears o_halted and fetch resumes.
- Wrap-around: redirect to 16'hFFFE with i_ready=1.
  - Required: o_pc sequence 16'hFFFE, 16'h0000, 16'h0002.
- Reset with a full FIFO and i_redirect asserted in the same cycle.
  - Required: next cycle o_valid=0, o_halted=0, o_imem_addr=RESET_PC.
